// File: rtl/slice_pkg.sv
// Shared definitions for the slice store responder.
//   SLICE_W : width of one slice (one bit per lane of the 5x5 state)
//   DEPTH   : number of slices (lines) held in the store
//   IDX_W   : line index width, DEPTH == 2**IDX_W
//   state_e : responder state encoding
package slice_pkg;

  localparam int unsigned SLICE_W = 25;
  localparam int unsigned DEPTH   = 64;
  localparam int unsigned IDX_W   = 6;

  typedef logic [SLICE_W-1:0] slice_t;
  typedef logic [IDX_W-1:0]   idx_t;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StLoad  = 2'b01,
    StServe = 2'b10,
    StDump  = 2'b11
  } state_e;

  localparam idx_t LastIdx = idx_t'(DEPTH - 1);

endpackage

// File: rtl/slice_ram.sv
// DEPTH x SLICE_W slice storage.
// Ports:
//   clk, rst        : clock, synchronous active-high reset (read register only)
//   we/waddr/wdata  : single synchronous write port
//   re/raddr/rdata  : registered read port, rdata holds until the next re
//   caddr/cdata     : combinational read port
// Contents are not reset. A read and write to the same address in one cycle
// returns the old contents.
module slice_ram
  import slice_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [IDX_W-1:0]   waddr,
  input  logic [SLICE_W-1:0] wdata,
  input  logic               re,
  input  logic [IDX_W-1:0]   raddr,
  output logic [SLICE_W-1:0] rdata,
  input  logic [IDX_W-1:0]   caddr,
  output logic [SLICE_W-1:0] cdata
);

  logic [SLICE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

  assign cdata = mem[caddr];

endmodule

// File: rtl/slice_store_responder.sv
// Responder for the permute controller's file/line interface. Loads DEPTH
// slices from an input stream, serves/accepts slices by line_index during the
// round, and streams the store back out on finish.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   load_req, in_valid, in_data    : load request and input stream
//   in_ready, load_done            : input handshake, load completion pulse
//   line_index, rd_req, rd_slice   : slice address, read strobe, registered data
//   wr_en, wr_slice                : slice write strobe and data
//   dump_req, out_valid, out_data  : dump request and output stream
//   out_ready, dump_done           : output handshake, dump completion pulse
//   busy                           : high while loading or dumping
module slice_store_responder
  import slice_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_req,
  input  logic               in_valid,
  input  logic [SLICE_W-1:0] in_data,
  output logic               in_ready,
  output logic               load_done,
  input  logic [IDX_W-1:0]   line_index,
  input  logic               rd_req,
  output logic [SLICE_W-1:0] rd_slice,
  input  logic               wr_en,
  input  logic [SLICE_W-1:0] wr_slice,
  input  logic               dump_req,
  output logic               out_valid,
  output logic [SLICE_W-1:0] out_data,
  input  logic               out_ready,
  output logic               dump_done,
  output logic               busy
);

  state_e state;
  idx_t   ptr;

  logic   ram_we;
  idx_t   ram_waddr;
  slice_t ram_wdata;
  logic   ram_re;

  // Single write port: the load stream and controller writes never overlap
  // because each is only honoured in its own state.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = ptr;
    ram_wdata = in_data;
    if (state == StLoad && in_valid) begin
      ram_we = 1'b1;
    end else if (state == StServe && wr_en) begin
      ram_we    = 1'b1;
      ram_waddr = line_index;
      ram_wdata = wr_slice;
    end
  end

  assign ram_re = (state == StServe) && rd_req;

  slice_ram u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (line_index),
    .rdata (rd_slice),
    .caddr (ptr),
    .cdata (out_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      ptr       <= '0;
      load_done <= 1'b0;
      dump_done <= 1'b0;
    end else begin
      load_done <= 1'b0;
      dump_done <= 1'b0;
      unique case (state)
        StIdle, StServe: begin
          // load_req takes priority over dump_req
          if (load_req) begin
            state <= StLoad;
            ptr   <= '0;
          end else if (dump_req) begin
            state <= StDump;
            ptr   <= '0;
          end
        end
        StLoad: begin
          if (in_valid) begin
            ptr <= ptr + 1'b1;
            if (ptr == LastIdx) begin
              load_done <= 1'b1;
              state     <= StServe;
            end
          end
        end
        StDump: begin
          if (out_ready) begin
            ptr <= ptr + 1'b1;
            if (ptr == LastIdx) begin
              dump_done <= 1'b1;
              state     <= StIdle;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state == StLoad);
  assign out_valid = (state == StDump);
  assign busy      = (state == StLoad) || (state == StDump);

endmodule

// File: tb/tb_slice_store_responder.sv
module tb_slice_store_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_req;
  logic        in_valid;
  logic [24:0] in_data;
  logic        in_ready;
  logic        load_done;
  logic [5:0]  line_index;
  logic        rd_req;
  logic [24:0] rd_slice;
  logic        wr_en;
  logic [24:0] wr_slice;
  logic        dump_req;
  logic        out_valid;
  logic [24:0] out_data;
  logic        out_ready;
  logic        dump_done;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [24:0] exp_mem [64];

  always #5 clk = ~clk;

  slice_store_responder dut (
    .clk        (clk),
    .rst        (rst),
    .load_req   (load_req),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .load_done  (load_done),
    .line_index (line_index),
    .rd_req     (rd_req),
    .rd_slice   (rd_slice),
    .wr_en      (wr_en),
    .wr_slice   (wr_slice),
    .dump_req   (dump_req),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .dump_done  (dump_done),
    .busy       (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  initial begin
    int idx;
    int c;
    rst = 1'b1; load_req = 1'b0; in_valid = 1'b0; in_data = '0;
    line_index = '0; rd_req = 1'b0; wr_en = 1'b0; wr_slice = '0;
    dump_req = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_in_ready", in_ready, 0);
    check("rst_load_done", load_done, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_dump_done", dump_done, 0);
    check("rst_busy", busy, 0);
    check("rst_rd_slice", rd_slice, 0);

    // rd_req outside SERVE is ignored
    line_index = 6'd3; rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    check("idle_rd_ignored", rd_slice, 0);
    check("idle_busy", busy, 0);

    // First load: data = k + 0x1000
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    check("load_busy", busy, 1);
    for (int k = 0; k < 64; k++) begin
      in_valid = 1'b1; in_data = 25'(k + 32'h1000);
      check("load_in_ready", in_ready, 1);
      check("load_done_early", load_done, 0);
      tick();
    end
    in_valid = 1'b0;
    check("load_done_pulse", load_done, 1);
    check("load_in_ready_off", in_ready, 0);
    check("load_busy_off", busy, 0);
    tick();
    check("load_done_one_cycle", load_done, 0);

    // Serve read index 5, held while rd_req low
    line_index = 6'd5; rd_req = 1'b1;
    tick();
    rd_req = 1'b0; line_index = 6'd7;
    check("serve_rd5", rd_slice, 32'h1005);
    tick(); tick();
    check("serve_rd5_hold", rd_slice, 32'h1005);

    // Stalled reload from SERVE, in_valid only on odd cycles, data = k
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    for (c = 0; c < 128; c++) begin
      in_valid = c[0];
      in_data  = 25'((c - 1) / 2);
      dump_req = (c == 10);
      check("stall_in_ready", in_ready, 1);
      check("stall_load_done_early", load_done, 0);
      tick();
    end
    in_valid = 1'b0; dump_req = 1'b0;
    check("stall_load_done", load_done, 1);
    check("stall_busy_off", busy, 0);
    for (int k = 0; k < 64; k++) exp_mem[k] = 25'(k);

    line_index = 6'd5; rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    check("reload_rd5", rd_slice, 5);

    // Write then read at 10
    line_index = 6'd10; wr_en = 1'b1; wr_slice = 25'h1ABCDEF;
    tick();
    wr_en = 1'b0; rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    exp_mem[10] = 25'h1ABCDEF;
    check("wr_rd10", rd_slice, 32'h1ABCDEF);

    // Same-cycle read and write at 11 returns old data
    line_index = 6'd11; rd_req = 1'b1; wr_en = 1'b1; wr_slice = 25'h00BEEF;
    tick();
    rd_req = 1'b0; wr_en = 1'b0;
    exp_mem[11] = 25'h00BEEF;
    check("rbw_old11", rd_slice, 11);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    check("rbw_new11", rd_slice, 32'h00BEEF);

    // Dump with out_ready pattern 1,0,0,1,0,0,...
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    idx = 0;
    for (c = 0; c < 400 && idx < 64; c++) begin
      out_ready = (c % 3 == 0);
      check("dump_out_valid", out_valid, 1);
      check("dump_data", out_data, exp_mem[idx]);
      check("dump_done_early", dump_done, 0);
      tick();
      if (out_ready) idx++;
    end
    out_ready = 1'b0;
    check("dump_beats", idx, 64);
    check("dump_done_pulse", dump_done, 1);
    check("dump_out_valid_off", out_valid, 0);
    check("dump_busy_off", busy, 0);
    tick();
    check("dump_done_one_cycle", dump_done, 0);
    check("dump_idle_valid", out_valid, 0);

    // Reset mid-dump after 20 accepted beats
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      check("rdump_data", out_data, exp_mem[k]);
      tick();
    end
    out_ready = 1'b0;
    check("rdump_pos20", out_data, exp_mem[20]);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rdump_out_valid", out_valid, 0);
    check("rdump_no_done", dump_done, 0);
    check("rdump_busy", busy, 0);
    tick();
    check("rdump_no_done_late", dump_done, 0);
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    check("rdump_restart_valid", out_valid, 1);
    check("rdump_restart_data0", out_data, exp_mem[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
